// File: rtl/mem_port_arbiter.sv
// Two-master arbiter onto a single TCM request/response bus: data has priority over fetch,
// fetch is protected by a starvation counter, and a tag FIFO steers in-order responses home.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_MAX      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic [31:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_rd_i,
    output logic        err_o
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTSTANDING - 1);

    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]              rd_ptr, wr_ptr;
    logic [CW-1:0]              count;
    logic [SW-1:0]              starve;
    logic                       lock_q, lock_d_q, err_q;

    logic d_req, i_req, full, empty, arb_d, sel_d, present, fire, pop, head_tag;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        d_req    = mem_d_rd_i | (|mem_d_wr_i);
        i_req    = mem_i_rd_i;
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        arb_d    = d_req && (!i_req || (starve < STARVE_LIM));
        // A stalled request keeps its slot: the registered winner overrides the live arbitration.
        sel_d    = lock_q ? lock_d_q : arb_d;
        present  = rst_i && !full && (lock_q || d_req || i_req);
        fire     = present && mem_accept_i;
        pop      = rst_i && mem_ack_i && !empty;
        head_tag = tag_q[rd_ptr];
    end

    assign mem_addr_o      = !present ? 32'h0 : (sel_d ? mem_d_addr_i : mem_i_pc_i);
    assign mem_data_wr_o   = (present && sel_d) ? mem_d_data_wr_i : 32'h0;
    assign mem_rd_o        = present && (sel_d ? mem_d_rd_i : 1'b1);
    assign mem_wr_o        = (present && sel_d) ? mem_d_wr_i : 4'h0;
    assign mem_i_accept_o  = fire && !sel_d;
    assign mem_d_accept_o  = fire && sel_d;
    assign mem_i_valid_o   = pop && !head_tag;
    assign mem_i_inst_o    = (pop && !head_tag) ? mem_data_rd_i : 32'h0;
    assign mem_d_ack_o     = pop && head_tag;
    assign mem_d_data_rd_o = (pop && head_tag) ? mem_data_rd_i : 32'h0;
    assign err_o           = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tag_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            starve   <= '0;
            lock_q   <= 1'b0;
            lock_d_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (fire) begin
                tag_q[wr_ptr] <= sel_d;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (fire && !pop)
                count <= count + 1'b1;
            else if (!fire && pop)
                count <= count - 1'b1;

            if (present && !mem_accept_i) begin
                lock_q   <= 1'b1;
                lock_d_q <= sel_d;
            end else if (fire) begin
                lock_q <= 1'b0;
            end

            if (!i_req || (fire && !sel_d))
                starve <= '0;
            else if (fire && sel_d && (starve < STARVE_LIM))
                starve <= starve + 1'b1;

            if (mem_ack_i && empty)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a queue-based reference model predicts each grant and
// each routed response; an independent monitor pops expected responses as the DUT emits them.
module tb_mem_port_arbiter;
    localparam int MO = 2;
    localparam int SM = 4;

    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        mem_i_rd_i = 1'b0;
    logic [31:0] mem_i_pc_i = '0;
    logic        mem_i_accept_o, mem_i_valid_o;
    logic [31:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i = '0, mem_d_data_wr_i = '0;
    logic        mem_d_rd_i = 1'b0;
    logic [3:0]  mem_d_wr_i = '0;
    logic        mem_d_accept_o, mem_d_ack_o;
    logic [31:0] mem_d_data_rd_o, mem_addr_o, mem_data_wr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic        mem_accept_i = 1'b0, mem_ack_i = 1'b0;
    logic [31:0] mem_data_rd_i = '0;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.MAX_OUTSTANDING(MO), .STARVE_MAX(SM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i), .mem_i_accept_o(mem_i_accept_o),
        .mem_i_valid_o(mem_i_valid_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_rd_i(mem_d_rd_i),
        .mem_d_wr_i(mem_d_wr_i), .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_data_rd_o(mem_d_data_rd_o), .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_accept_i(mem_accept_i),
        .mem_ack_i(mem_ack_i), .mem_data_rd_i(mem_data_rd_i), .err_o(err_o)
    );

    typedef struct { bit tag; logic [31:0] data; } resp_t;
    resp_t exp_q[$];
    int    out_q[$];
    int    starve = 0, lk_src = 0, last_acc = 0;
    bit    lk = 0, err_exp = 0;
    bit    i_pend = 0, d_pend = 0, d_rd = 0;
    logic [31:0] i_pc = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wr = '0;
    int    checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic new_i();
        i_pend = 1; i_pc = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_d();
        d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
        if ($urandom_range(1) == 1) begin d_rd = 1; d_wr = 4'h0; end
        else begin d_rd = 0; d_wr = 4'($urandom_range(15, 1)); end
    endtask

    // One bus cycle: drive, predict from the arbitration rules, compare, advance the model.
    task automatic cycle(input bit acc, input bit ack, input logic [31:0] ackd);
        int src;
        bit fire;
        @(negedge clk_i);
        mem_i_rd_i      = i_pend;
        mem_i_pc_i      = i_pend ? i_pc : $urandom;
        mem_d_rd_i      = d_pend & d_rd;
        mem_d_wr_i      = d_pend ? d_wr : 4'h0;
        mem_d_addr_i    = d_pend ? d_addr : $urandom;
        mem_d_data_wr_i = d_pend ? d_wdata : $urandom;
        mem_accept_i    = acc;
        mem_ack_i       = ack;
        mem_data_rd_i   = ackd;
        #1;
        chk("err_o", {31'h0, err_o}, {31'h0, err_exp});
        src = -1;
        if (out_q.size() < MO) begin
            if (lk) src = lk_src;
            else if (d_pend && (!i_pend || starve < SM)) src = 1;
            else if (i_pend) src = 0;
        end
        fire = (src >= 0) && acc;
        chk("mem_rd_o", {31'h0, mem_rd_o}, (src == 0) ? 1 : (src == 1) ? {31'h0, d_rd} : 0);
        chk("mem_wr_o", {28'h0, mem_wr_o}, (src == 1) ? {28'h0, d_wr} : 0);
        chk("mem_addr_o", mem_addr_o, (src == 0) ? i_pc : (src == 1) ? d_addr : 32'h0);
        chk("mem_data_wr_o", mem_data_wr_o, (src == 1) ? d_wdata : 32'h0);
        chk("i_accept", {31'h0, mem_i_accept_o}, {31'h0, fire && src == 0});
        chk("d_accept", {31'h0, mem_d_accept_o}, {31'h0, fire && src == 1});
        last_acc = mem_d_accept_o ? 2 : mem_i_accept_o ? 1 : 0;
        if (ack) begin
            if (out_q.size() > 0) exp_q.push_back('{tag: out_q.pop_front() == 1, data: ackd});
            else err_exp = 1;
        end
        if (fire) out_q.push_back(src);
        if (!i_pend || (fire && src == 0)) starve = 0;
        else if (fire && src == 1 && starve < SM) starve++;
        if (src >= 0 && !acc) begin lk = 1; lk_src = src; end
        else if (fire) lk = 0;
        if (fire && src == 0) i_pend = 0;
        if (fire && src == 1) d_pend = 0;
    endtask

    task automatic rnd_cycle(input int pi, input int pd, input int pa, input int pk, input bit stray);
        bit ack;
        if (!i_pend && $urandom_range(99) < pi) new_i();
        if (!d_pend && $urandom_range(99) < pd) new_d();
        ack = (out_q.size() > 0 || stray) && ($urandom_range(99) < pk);
        cycle($urandom_range(99) < pa, ack, $urandom);
    endtask

    task automatic drain();
        while (out_q.size() > 0) cycle(0, 1, $urandom);
    endtask

    task automatic settle();
        while (i_pend || d_pend) cycle(1, out_q.size() > 0, $urandom);
        drain();
    endtask

    task automatic check_outputs_zero(input string tagname);
        chk({tagname, "_rd"}, {31'h0, mem_rd_o}, 0);
        chk({tagname, "_wr"}, {28'h0, mem_wr_o}, 0);
        chk({tagname, "_addr"}, mem_addr_o, 0);
        chk({tagname, "_accepts"}, {30'h0, mem_i_accept_o, mem_d_accept_o}, 0);
        chk({tagname, "_resp"}, {30'h0, mem_i_valid_o, mem_d_ack_o}, 0);
        chk({tagname, "_data"}, mem_i_inst_o | mem_d_data_rd_o | mem_data_wr_o, 0);
        chk({tagname, "_err"}, {31'h0, err_o}, 0);
    endtask

    // Response monitor: every DUT response must match the head of the expected queue.
    always @(negedge clk_i) begin
        #2;
        if (rst_i) begin
            if (mem_i_valid_o || mem_d_ack_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected actual=i%0b/d%0b required=none", mem_i_valid_o, mem_d_ack_o);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("resp_i_valid", {31'h0, mem_i_valid_o}, {31'h0, !e.tag});
                    chk("resp_d_ack", {31'h0, mem_d_ack_o}, {31'h0, e.tag});
                    chk("resp_i_inst", mem_i_inst_o, e.tag ? 32'h0 : e.data);
                    chk("resp_d_data", mem_d_data_rd_o, e.tag ? e.data : 32'h0);
                end
            end else if (exp_q.size() > 0) begin
                checks++; errors++;
                $display("FAIL resp_missing actual=none required=%0d pending", exp_q.size());
                void'(exp_q.pop_front());
            end
        end
    end

    int pi_t[4] = '{80, 100, 60, 90};
    int pd_t[4] = '{80, 100, 60, 90};
    int pa_t[4] = '{70, 100, 30, 90};
    int pk_t[4] = '{50, 90, 30, 10};

    initial begin
        #1;
        mem_i_rd_i = 1; mem_d_rd_i = 1; mem_accept_i = 1; mem_ack_i = 1;
        #1;
        check_outputs_zero("reset");
        mem_i_rd_i = 0; mem_d_rd_i = 0; mem_accept_i = 0; mem_ack_i = 0;
        #20;
        @(negedge clk_i); #3; rst_i = 1;

        // Single fetch, response one cycle later.
        i_pend = 1; i_pc = 32'h8000_0000;
        cycle(1, 0, 0);
        chk("fetch_accept", last_acc, 1);
        cycle(0, 1, 32'h0000_0013);

        // Continuous data traffic against one waiting fetch: DDDD then I.
        new_i();
        for (int k = 0; k < 5; k++) begin
            if (!d_pend) new_d();
            cycle(1, out_q.size() > 0, $urandom);
            chk("starve_order", last_acc, (k < 4) ? 2 : 1);
        end
        d_pend = 0;
        cycle(0, out_q.size() > 0, $urandom);
        settle();

        // Stalled data write keeps the bus while a fetch shows up.
        d_pend = 1; d_rd = 0; d_wr = 4'hF; d_addr = 32'h8000_1000; d_wdata = $urandom;
        cycle(0, 0, 0);
        new_i();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        chk("lock_d_held", last_acc, 2);
        settle();

        // Fill the FIFO, then ack together with a new request: still blocked.
        new_i(); new_d();
        cycle(1, 0, 0);
        if (!i_pend) new_i();
        if (!d_pend) new_d();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("full_block", last_acc, 0);
        cycle(1, 1, $urandom);
        chk("full_ack_block", last_acc, 0);
        settle();

        // I, D, I with in-order responses 0x11, 0x22, 0x33.
        new_i(); cycle(1, 0, 0);
        new_d(); cycle(1, 0, 0);
        new_i(); cycle(1, 1, 32'h11);
        cycle(1, 1, 32'h22);
        cycle(0, 1, 32'h33);
        settle();

        for (int p = 0; p < 4; p++)
            for (int n = 0; n < 500; n++) rnd_cycle(pi_t[p], pd_t[p], pa_t[p], pk_t[p], 0);
        settle();

        // Stray ack sets the sticky error.
        cycle(0, 1, $urandom);
        cycle(0, 0, 0);
        chk("err_set", {31'h0, err_o}, 1);
        for (int n = 0; n < 100; n++) rnd_cycle(70, 70, 60, 50, 1);

        // Asynchronous reset in the middle of traffic.
        new_i(); new_d();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        @(negedge clk_i); #3;
        rst_i = 0;
        #1;
        check_outputs_zero("midreset");
        out_q.delete(); exp_q.delete();
        starve = 0; lk = 0; err_exp = 0;
        @(negedge clk_i); #3;
        rst_i = 1;
        for (int n = 0; n < 300; n++) rnd_cycle(70, 70, 70, 60, 0);
        settle();
        @(negedge clk_i); #3;
        chk("resp_leftover", exp_q.size(), 0);
        chk("err_clear", {31'h0, err_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
